// File: rtl/counter_load_arbiter.sv
// Round-robin arbiter that hands tenure of one shared loadable up-counter to N requesters.
// A tenure loads the winner's value, then runs until the counter hits all-ones or MAX_HOLD cycles pass.
module counter_load_arbiter #(
    parameter int N        = 4,
    parameter int W        = 4,
    parameter int MAX_HOLD = 8
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [N-1:0]   req_i,
    input  logic [N*W-1:0] load_val_i,
    input  logic [W-1:0]   count_i,
    output logic           load_o,
    output logic [W-1:0]   load_val_o,
    output logic [N-1:0]   gnt_o,
    output logic [N-1:0]   owner_o,
    output logic           busy_o,
    output logic           done_o
);
    // state     | meaning
    // IDLE      | no tenure; arbitrate req_i from r_rr_ptr
    // LOAD      | drive winner's value onto counter load, pulse grant
    // RUN       | winner owns the free-running counter
    // RELEASE   | tenure end pulse, advance round-robin pointer

    localparam int IW = $clog2(N);
    localparam int HW = $clog2(MAX_HOLD + 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_LOAD    = 2'd1,
        S_RUN     = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    state_t          r_state;
    logic [IW-1:0]   r_rr_ptr;
    logic [HW-1:0]   r_hold_cnt;
    logic [IW-1:0]   r_idx;
    logic [W-1:0]    r_val;

    state_t          w_state_nxt;
    logic [IW-1:0]   w_rr_nxt;
    logic [HW-1:0]   w_hold_nxt;
    logic [IW-1:0]   w_idx_nxt;
    logic [W-1:0]    w_val_nxt;

    logic            w_found;
    logic [IW-1:0]   w_win_idx;
    logic [W-1:0]    w_win_val;
    logic [N-1:0]    w_onehot;

    function automatic int rr_pos(input logic [IW-1:0] base, input int k);
        return (int'(base) + k) % N;
    endfunction

    always_comb begin
        w_found   = 1'b0;
        w_win_idx = '0;
        w_win_val = '0;
        for (int k = 0; k < N; k++) begin
            if (!w_found && req_i[rr_pos(r_rr_ptr, k)]) begin
                w_found   = 1'b1;
                w_win_idx = IW'(rr_pos(r_rr_ptr, k));
                w_win_val = load_val_i[rr_pos(r_rr_ptr, k)*W +: W];
            end
        end
    end

    // Hold timer counts down from MAX_HOLD-1; zero on a RUN cycle is the last allowed cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_rr_nxt    = r_rr_ptr;
        w_hold_nxt  = r_hold_cnt;
        w_idx_nxt   = r_idx;
        w_val_nxt   = r_val;
        unique case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_idx_nxt   = w_win_idx;
                    w_val_nxt   = w_win_val;
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                w_hold_nxt  = HOLD_LAST;
                w_state_nxt = S_RUN;
            end
            S_RUN: begin
                if (count_i == '1 || r_hold_cnt == '0) begin
                    w_state_nxt = S_RELEASE;
                end else begin
                    w_hold_nxt = r_hold_cnt - 1'b1;
                end
            end
            S_RELEASE: begin
                w_rr_nxt    = (r_idx == IW'(N - 1)) ? '0 : r_idx + 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_rr_ptr   <= '0;
            r_hold_cnt <= '0;
            r_idx      <= '0;
            r_val      <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_rr_ptr   <= w_rr_nxt;
            r_hold_cnt <= w_hold_nxt;
            r_idx      <= w_idx_nxt;
            r_val      <= w_val_nxt;
        end
    end

    assign w_onehot   = {{(N-1){1'b0}}, 1'b1} << r_idx;
    assign load_o     = (r_state == S_LOAD);
    assign load_val_o = r_val;
    assign gnt_o      = (r_state == S_LOAD) ? w_onehot : '0;
    assign owner_o    = (r_state != S_IDLE) ? w_onehot : '0;
    assign busy_o     = (r_state != S_IDLE);
    assign done_o     = (r_state == S_RELEASE);

endmodule

// File: tb/tb_counter_load_arbiter.sv
// Directed bench for counter_load_arbiter with a behavioural loadable 4-bit up-counter.
module tb_counter_load_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [15:0] load_val;
    logic [3:0]  cnt = 4'd0;
    logic        load_o;
    logic [3:0]  load_val_o;
    logic [3:0]  gnt_o;
    logic [3:0]  owner_o;
    logic        busy_o;
    logic        done_o;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    counter_load_arbiter #(.N(4), .W(4), .MAX_HOLD(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_i      (req),
        .load_val_i (load_val),
        .count_i    (cnt),
        .load_o     (load_o),
        .load_val_o (load_val_o),
        .gnt_o      (gnt_o),
        .owner_o    (owner_o),
        .busy_o     (busy_o),
        .done_o     (done_o)
    );

    always_ff @(posedge clk) begin
        if (load_o) cnt <= load_val_o;
        else        cnt <= cnt + 4'd1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_outs(input string tag, input logic ld, input logic [3:0] lv,
                               input logic [3:0] g, input logic [3:0] ow,
                               input logic b, input logic d);
        check({tag, ".load"},  32'(load_o),     32'(ld));
        check({tag, ".lval"},  32'(load_val_o), 32'(lv));
        check({tag, ".gnt"},   32'(gnt_o),      32'(g));
        check({tag, ".owner"}, 32'(owner_o),    32'(ow));
        check({tag, ".busy"},  32'(busy_o),     32'(b));
        check({tag, ".done"},  32'(done_o),     32'(d));
    endtask

    // Wait up to 20 cycles for load_o (sel=0) or done_o (sel=1); a timeout counts as a failure.
    task automatic wait_for(input string tag, input bit sel);
        bit seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            seen = sel ? done_o : load_o;
        end
        check({tag, ".seen"}, 32'(seen), 32'd1);
    endtask

    initial begin
        logic [3:0] exp_gnt [5];
        logic [3:0] exp_val [5];
        bit         saw_grant;

        // 1: reset held with all requests up
        reset = 1'b1; req = 4'hF; load_val = 16'hFFFF;
        repeat (3) begin
            @(negedge clk);
            expect_outs("t1_reset", 1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
        end
        reset = 1'b0; req = 4'h0; load_val = 16'h0000;
        @(negedge clk);
        expect_outs("t1_idle", 1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);

        // 2: full-length tenure, 3..A
        req = 4'b0010; load_val = 16'h0030;
        @(negedge clk);
        expect_outs("t2_load", 1'b1, 4'h3, 4'b0010, 4'b0010, 1'b1, 1'b0);
        req = 4'h0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("t2_count", 32'(cnt), 32'(4'h3 + 4'(i)));
            expect_outs("t2_run", 1'b0, 4'h3, 4'h0, 4'b0010, 1'b1, 1'b0);
        end
        @(negedge clk);
        expect_outs("t2_release", 1'b0, 4'h3, 4'h0, 4'b0010, 1'b1, 1'b1);
        @(negedge clk);
        expect_outs("t2_after", 1'b0, 4'h3, 4'h0, 4'h0, 1'b0, 1'b0);

        // 3: tenure ends early on all-ones
        req = 4'b0010; load_val = 16'h00C0;
        @(negedge clk);
        expect_outs("t3_load", 1'b1, 4'hC, 4'b0010, 4'b0010, 1'b1, 1'b0);
        req = 4'h0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t3_count", 32'(cnt), 32'(4'hC + 4'(i)));
            expect_outs("t3_run", 1'b0, 4'hC, 4'h0, 4'b0010, 1'b1, 1'b0);
        end
        @(negedge clk);
        expect_outs("t3_release", 1'b0, 4'hC, 4'h0, 4'b0010, 1'b1, 1'b1);
        @(negedge clk);
        expect_outs("t3_after", 1'b0, 4'hC, 4'h0, 4'h0, 1'b0, 1'b0);

        // 4: all requesting, rotation from pointer 0
        reset = 1'b1;
        @(negedge clk);
        expect_outs("t4_reset", 1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
        reset = 1'b0; req = 4'hF; load_val = 16'hBCDE;
        exp_gnt = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        exp_val = '{4'hE, 4'hD, 4'hC, 4'hB, 4'hE};
        for (int g = 0; g < 5; g++) begin
            wait_for("t4_load", 1'b0);
            check("t4_gnt",  32'(gnt_o),      32'(exp_gnt[g]));
            check("t4_lval", 32'(load_val_o), 32'(exp_val[g]));
        end
        req = 4'h0;
        wait_for("t4_done", 1'b1);
        @(negedge clk);
        check("t4_idle_busy", 32'(busy_o), 32'd0);

        // 5: reset during the third RUN cycle
        req = 4'b0010; load_val = 16'h0060;
        @(negedge clk);
        expect_outs("t5_load", 1'b1, 4'h6, 4'b0010, 4'b0010, 1'b1, 1'b0);
        req = 4'h0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t5_count", 32'(cnt), 32'(4'h6 + 4'(i)));
        end
        reset = 1'b1;
        @(negedge clk);
        expect_outs("t5_reset", 1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
        reset = 1'b0; req = 4'b0100; load_val = 16'h0700;
        @(negedge clk);
        expect_outs("t5_regrant", 1'b1, 4'h7, 4'b0100, 4'b0100, 1'b1, 1'b0);
        req = 4'h0;
        wait_for("t5_done", 1'b1);
        @(negedge clk);
        check("t5_idle_busy", 32'(busy_o), 32'd0);

        // 6: short pulse during a tenure is ignored; all-ones load gives one RUN cycle
        req = 4'b1000; load_val = 16'hF000;
        @(negedge clk);
        expect_outs("t6_load", 1'b1, 4'hF, 4'b1000, 4'b1000, 1'b1, 1'b0);
        req = 4'b0001; load_val = 16'hF005;
        @(negedge clk);
        check("t6_count", 32'(cnt), 32'hF);
        expect_outs("t6_run", 1'b0, 4'hF, 4'h0, 4'b1000, 1'b1, 1'b0);
        req = 4'h0;
        @(negedge clk);
        expect_outs("t6_release", 1'b0, 4'hF, 4'h0, 4'b1000, 1'b1, 1'b1);
        @(negedge clk);
        expect_outs("t6_after", 1'b0, 4'hF, 4'h0, 4'h0, 1'b0, 1'b0);
        saw_grant = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (load_o || gnt_o != 4'h0 || busy_o) saw_grant = 1'b1;
        end
        check("t6_no_grant", 32'(saw_grant), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
